soc_led_clockwork: RTL and testbench



---
 rtl/soc_led_clockwork.sv | 159 +++++++++++++++
 tb/tb_soc_led_clockwork.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/soc_led_clockwork.sv
// LED comet rotator with an 8N1 UART report of each new pattern; RXD synchronised but reserved.
// Latency: LEDS and TXD change on the step edge itself (start bit driven on the same edge as the new pattern).
// Backpressure: none; a step arriving while a frame is still in flight drops that byte, LEDS still advance.
module soc_led_clockwork #(
  parameter int STEP_DIV     = 64,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] LEDS,
  input  logic       RXD,
  output logic       TXD
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [7:0] LEDS_RESET = 8'b0000_0111;

  // A frame must fit between two steps, otherwise bytes would be lost.
  generate
    if (STEP_DIV < 2 || CLKS_PER_BIT < 1 || STEP_DIV < 10 * CLKS_PER_BIT) begin : g_bad_params
      $error("soc_led_clockwork: need STEP_DIV >= 2, CLKS_PER_BIT >= 1, STEP_DIV >= 10*CLKS_PER_BIT");
    end
  endgenerate

  logic [1:0]    rxd_sync;
  logic          unused_rxd;
  logic [SW-1:0] step_cnt;
  logic          step_wrap;
  logic [7:0]    leds_next;
  logic [1:0]    tx_state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_shift;
  logic          bit_end;

  // Two-flop synchroniser for the receive pin; idles high like a UART line.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rxd_sync <= 2'b11;
    end else begin
      rxd_sync <= {rxd_sync[0], RXD};
    end
  end

  // Receive path is reserved; the synchronised level intentionally goes nowhere.
  assign unused_rxd = rxd_sync[1];

  assign step_wrap = (step_cnt == STEP_LAST);
  assign leds_next = {LEDS[6:0], LEDS[7]};
  assign bit_end   = (clk_cnt == BIT_LAST);

  // Free-running step divider, 0 .. STEP_DIV-1.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      step_cnt <= '0;
    end else if (step_wrap) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Comet pattern rotates left by one on every divider wrap.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      LEDS <= LEDS_RESET;
    end else if (step_wrap) begin
      LEDS <= leds_next;
    end
  end

  // UART transmitter: start bit, 8 data bits LSB first, stop bit; frames launched by steps.
  // A step landing on the last stop-bit cycle chains straight into the next start bit so that
  // STEP_DIV == 10*CLKS_PER_BIT loses no byte.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_state <= ST_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      TXD      <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          TXD     <= 1'b1;
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (step_wrap) begin
            tx_shift <= leds_next;
            tx_state <= ST_START;
            TXD      <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            tx_state <= ST_DATA;
            TXD      <= tx_shift[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (bit_cnt == 3'd7) begin
              tx_state <= ST_STOP;
              TXD      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              TXD     <= tx_shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (step_wrap) begin
              tx_shift <= leds_next;
              tx_state <= ST_START;
              TXD      <= 1'b0;
            end else begin
              tx_state <= ST_IDLE;
              TXD      <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          tx_state <= ST_IDLE;
          clk_cnt  <= '0;
          bit_cnt  <= '0;
          TXD      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_led_clockwork.sv
// Bench for soc_led_clockwork: three instances (defaults with RXD=0, defaults with random RXD,
// STEP_DIV=20/CLKS_PER_BIT=2 with random RXD) checked every cycle against an arithmetic model,
// plus a bit-centre UART decoder on the default instance and literal pattern pins.
module tb_soc_led_clockwork;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       rxd_zero = 1'b0;
  logic       rxd_rnd = 1'b1;
  logic [7:0] leds0, leds1, leds2;
  logic       txd0, txd1, txd2;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [7:0] exp_bytes [8] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07};

  soc_led_clockwork dut0 (.CLK(CLK), .RESET(RESET), .LEDS(leds0), .RXD(rxd_zero), .TXD(txd0));
  soc_led_clockwork dut1 (.CLK(CLK), .RESET(RESET), .LEDS(leds1), .RXD(rxd_rnd),  .TXD(txd1));
  soc_led_clockwork #(.STEP_DIV(20), .CLKS_PER_BIT(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .LEDS(leds2), .RXD(rxd_rnd), .TXD(txd2));

  always #5 CLK = ~CLK;

  // Edge number since the last reset release (edge 1 = first rising edge after release).
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) n <= 0;
    else        n <= n + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %02h expected %02h", name, n, act, exp);
    end
  endtask

  // Pattern after t edges: the reset comet rotated left once per completed step.
  function automatic logic [7:0] model_leds(input int t, input int sd);
    int k = (t / sd) % 8;
    logic [7:0] p = 8'h07;
    for (int i = 0; i < k; i++) p = {p[6:0], p[7]};
    return p;
  endfunction

  // Line level after t edges: a 10-bit frame of the current pattern starts at each step edge.
  function automatic logic model_txd(input int t, input int sd, input int cpb);
    int k = t / sd;
    int o;
    int b;
    logic [7:0] p;
    if (k == 0) return 1'b1;
    o = t - k * sd;
    if (o >= 10 * cpb) return 1'b1;
    b = o / cpb;
    p = model_leds(t, sd);
    if (b == 0) return 1'b0;
    if (b <= 8) return p[b-1];
    return 1'b1;
  endfunction

  // Every-cycle comparison against the model, plus literal pins on the default instance.
  always @(negedge CLK) begin
    check("leds_dut0", leds0, model_leds(n, 64));
    check("txd_dut0", {7'd0, txd0}, {7'd0, model_txd(n, 64, 4)});
    check("leds_dut1_rxd", leds1, model_leds(n, 64));
    check("txd_dut1_rxd", {7'd0, txd1}, {7'd0, model_txd(n, 64, 4)});
    check("leds_dut2_var", leds2, model_leds(n, 20));
    check("txd_dut2_var", {7'd0, txd2}, {7'd0, model_txd(n, 20, 2)});
    if (RESET) begin
      if (n == 63)  check("pin_leds_63", leds0, 8'h07);
      if (n == 64)  check("pin_leds_64", leds0, 8'h0E);
      if (n == 319) check("pin_leds_319", leds0, 8'h70);
      if (n == 320) check("pin_leds_320", leds0, 8'hE0);
      if (n == 384) check("pin_leds_384", leds0, 8'hC1);
      if (n == 511) check("pin_leds_511", leds0, 8'h83);
      if (n == 512) check("pin_leds_512", leds0, 8'h07);
      if (n == 20)  check("pin_var_leds_20", leds2, 8'h0E);
    end
  end

  // UART decoder on dut0: sample each bit 2 cycles into its 4-cycle window.
  int         dec_cnt = -1;
  int         dec_idx = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      dec_cnt = -1;
      dec_idx = 0;
    end else if (!CLK) begin
      if (dec_cnt < 0) begin
        if (txd0 == 1'b0) dec_cnt = 0;
      end else begin
        dec_cnt++;
        if (dec_cnt % 4 == 2) begin
          if (dec_cnt / 4 == 0) begin
            check("uart_start_bit", {7'd0, txd0}, 8'h00);
          end else if (dec_cnt / 4 <= 8) begin
            dec_byte[dec_cnt/4 - 1] = txd0;
          end else begin
            check("uart_stop_bit", {7'd0, txd0}, 8'h01);
            check("uart_byte", dec_byte, exp_bytes[dec_idx % 8]);
            dec_idx++;
            dec_cnt = -1;
          end
        end
      end
    end
  end

  // Random RXD activity, changed well away from the clock edge.
  initial begin
    forever begin
      @(posedge CLK);
      #3 rxd_rnd = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_leds", leds0, 8'h07);
    check("reset_txd", {7'd0, txd0}, 8'h01);
    check("reset_var_leds", leds2, 8'h07);
    #2 RESET = 1'b1;

    // Run into step 3 (mid-frame for 0x38), then reset asynchronously.
    repeat (200) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("midreset_leds", leds0, 8'h07);
    check("midreset_txd", {7'd0, txd0}, 8'h01);
    check("midreset_var_leds", leds2, 8'h07);
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;

    // Nine steps plus the ninth frame's completion.
    repeat (620) @(posedge CLK);
    @(negedge CLK);
    check("uart_byte_count", 8'(dec_idx), 8'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
